// File: rtl/linear_layer_i4xi4_q_srl_fifo.sv
// Shift-register FIFO with first-word fall-through output and registered status flags.
// Define LINEAR_LAYER_SRL_FIFO_ERR_FLAG_EN to build the sticky overflow/underflow flags.
module linear_layer_i4xi4_q_srl_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  output logic                  if_almost_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_count,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_AF   = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_WIDTH-1:0] HD_ONE   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   count, count_nxt;
  // head tracks count-1 so the output mux needs no subtractor
  logic [ADDR_WIDTH-1:0] head, head_nxt;
  logic                  full_n, almost_full_n, empty_n;
  logic                  wr, rd;

  assign wr = if_write_ce & if_write & full_n & ~reset;
  assign rd = if_read_ce & if_read & empty_n & ~reset;

  always_comb begin
    count_nxt = count;
    head_nxt  = head;
    if (wr && !rd) begin
      count_nxt = count + CNT_ONE;
      head_nxt  = head + HD_ONE;
    end else if (rd && !wr) begin
      count_nxt = count - CNT_ONE;
      head_nxt  = head - HD_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count         <= '0;
      head          <= '1;
      full_n        <= 1'b1;
      almost_full_n <= 1'b1;
      empty_n       <= 1'b0;
    end else begin
      count         <= count_nxt;
      head          <= head_nxt;
      full_n        <= (count_nxt != CNT_FULL);
      almost_full_n <= (count_nxt < CNT_AF);
      empty_n       <= (count_nxt != '0);
    end
  end

  // storage carries no reset so it maps onto shift-register primitives
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign if_dout          = mem[head];
  assign if_count         = count;
  assign if_full_n        = full_n;
  assign if_almost_full_n = almost_full_n;
  assign if_empty_n       = empty_n;

`ifdef LINEAR_LAYER_SRL_FIFO_ERR_FLAG_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (if_write_ce & if_write & ~full_n) ovf_q <= 1'b1;
      if (if_read_ce & if_read & ~empty_n)  unf_q <= 1'b1;
    end
  end

  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;
`else
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
`endif

endmodule
